// File: rtl/shift_rotate_unit.sv
// Barrel shifter/rotator with valid/ready handshake: ROL/SLL/ROR/SRL/SRA on a WIDTH-bit operand,
// either one output register (PIPE=0) or one register per power-of-two shift stage (PIPE=1).
module shift_rotate_unit #(
  parameter int WIDTH = 16,
  parameter int PIPE  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_cnt,
  input  logic [2:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_zero,
  output logic                       out_err
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int NREG  = (PIPE != 0) ? CNT_W : 1;

  // One power-of-two move; SRA fills from the sign captured at issue, not the current MSB.
  function automatic logic [WIDTH-1:0] stage_fn(input logic [WIDTH-1:0] d,
                                                input logic [2:0]       op,
                                                input logic             sgn,
                                                input logic             en,
                                                input int               sh);
    logic [WIDTH-1:0] fill;
    fill     = sgn ? ~({WIDTH{1'b1}} >> sh) : '0;
    stage_fn = d;
    if (en) begin
      case (op)
        3'b000:  stage_fn = (d << sh) | (d >> (WIDTH - sh));
        3'b001:  stage_fn = d << sh;
        3'b010:  stage_fn = (d >> sh) | (d << (WIDTH - sh));
        3'b011:  stage_fn = d >> sh;
        3'b100:  stage_fn = (d >> sh) | fill;
        default: stage_fn = d;
      endcase
    end
  endfunction

  logic [NREG-1:0]  v_q;
  logic [WIDTH-1:0] d_q   [NREG];
  logic [2:0]       op_q  [NREG];
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [NREG-1:0]  sgn_q;
  logic             zero_q;
  logic             err_q;

  logic [NREG-1:0]  src_v;
  logic [WIDTH-1:0] src_d   [NREG];
  logic [2:0]       src_op  [NREG];
  logic [CNT_W-1:0] src_cnt [NREG];
  logic [NREG-1:0]  src_sgn;
  logic [WIDTH-1:0] nxt_d   [NREG];
  logic [NREG-1:0]  adv;

  // A slot stalls only when it and every slot after it is full and the output is blocked.
  always_comb begin
    logic full;
    full = 1'b1;
    adv  = '0;
    for (int j = NREG - 1; j >= 0; j--) begin
      full   = full & v_q[j];
      adv[j] = out_ready | ~full;
    end
  end

  always_comb begin
    src_v[0]   = in_valid;
    src_d[0]   = in_data;
    src_op[0]  = in_op;
    src_cnt[0] = in_cnt;
    src_sgn[0] = in_data[WIDTH-1];
    for (int j = 1; j < NREG; j++) begin
      src_v[j]   = v_q[j-1];
      src_d[j]   = d_q[j-1];
      src_op[j]  = op_q[j-1];
      src_cnt[j] = cnt_q[j-1];
      src_sgn[j] = sgn_q[j-1];
    end
  end

  // Slot j applies only stage j when pipelined, or the whole LSB-first chain otherwise.
  always_comb begin
    logic [WIDTH-1:0] t;
    t = '0;
    for (int j = 0; j < NREG; j++) begin
      t = src_d[j];
      for (int k = 0; k < CNT_W; k++)
        t = stage_fn(t, src_op[j], src_sgn[j], src_cnt[j][k] && (PIPE == 0 || k == j), 1 << k);
      nxt_d[j] = t;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= '0;
      sgn_q  <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
      for (int j = 0; j < NREG; j++) begin
        d_q[j]   <= '0;
        op_q[j]  <= '0;
        cnt_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < NREG; j++) begin
        if (adv[j]) begin
          v_q[j] <= src_v[j];
          if (src_v[j]) begin
            d_q[j]   <= nxt_d[j];
            op_q[j]  <= src_op[j];
            cnt_q[j] <= src_cnt[j];
            sgn_q[j] <= src_sgn[j];
          end
        end
      end
      if (adv[NREG-1] && src_v[NREG-1]) begin
        zero_q <= (nxt_d[NREG-1] == '0);
        err_q  <= (src_op[NREG-1] > 3'd4);
      end
    end
  end

  // The last slot's control fields have no consumer; flags are kept in zero_q/err_q instead.
  logic unused_meta;
  assign unused_meta = ^{op_q[NREG-1], cnt_q[NREG-1], sgn_q[NREG-1]};

  assign in_ready  = adv[0] & ~rst;
  assign out_valid = v_q[NREG-1];
  assign out_data  = d_q[NREG-1];
  assign out_zero  = zero_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Bench for shift_rotate_unit: a 16-bit pipelined instance and a 32-bit single-register instance,
// checked against a bit-index reference model with directed, backpressure, reset and random traffic.
module tb_shift_rotate_unit;

  logic        clk;
  logic        rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero, a_out_err;
  logic [15:0] a_in_data, a_out_data;
  logic [3:0]  a_in_cnt;
  logic [2:0]  a_in_op;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero, b_out_err;
  logic [31:0] b_in_data, b_out_data;
  logic [4:0]  b_in_cnt;
  logic [2:0]  b_in_op;

  int n_checks;
  int n_fail;

  shift_rotate_unit #(.WIDTH(16), .PIPE(1)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_cnt(a_in_cnt), .in_op(a_in_op),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_zero(a_out_zero), .out_err(a_out_err)
  );

  shift_rotate_unit #(.WIDTH(32), .PIPE(0)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_cnt(b_in_cnt), .in_op(b_in_op),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_zero(b_out_zero), .out_err(b_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Result bit i is taken from whichever source bit the operation's definition names.
  function automatic logic [31:0] ref_model(input int w, input logic [31:0] d,
                                            input logic [2:0] op, input int c);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (op)
        3'd0:    r[i] = d[(i - c + w) % w];
        3'd1:    r[i] = (i >= c) ? d[i - c] : 1'b0;
        3'd2:    r[i] = d[(i + c) % w];
        3'd3:    r[i] = (i + c < w) ? d[i + c] : 1'b0;
        3'd4:    r[i] = (i + c < w) ? d[i + c] : d[w - 1];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [31:0] d,
                       input logic [2:0] op, input int c, input logic r);
    if (sel == 0) begin
      a_in_valid = v; a_in_data = d[15:0]; a_in_op = op; a_in_cnt = 4'(c); a_out_ready = r;
    end else begin
      b_in_valid = v; b_in_data = d; b_in_op = op; b_in_cnt = 5'(c); b_out_ready = r;
    end
  endtask

  task automatic sample(input int sel, output logic ir, output logic ov,
                        output logic [31:0] od, output logic oz, output logic oe);
    if (sel == 0) begin
      ir = a_in_ready; ov = a_out_valid; od = {16'h0, a_out_data}; oz = a_out_zero; oe = a_out_err;
    end else begin
      ir = b_in_ready; ov = b_out_valid; od = b_out_data; oz = b_out_zero; oe = b_out_err;
    end
  endtask

  task automatic run_op(input int sel, input logic [31:0] d, input logic [2:0] op, input int c,
                        input logic [31:0] ed, input logic ez, input logic ee,
                        input int elat, input string nm);
    logic ir, ov, oz, oe;
    logic [31:0] od;
    int k;
    drive(sel, 1'b1, d, op, c, 1'b1);
    #1;
    sample(sel, ir, ov, od, oz, oe);
    n_checks++;
    if (ir !== 1'b1) begin
      n_fail++; $display("FAIL %s in_ready: got %b expected 1", nm, ir);
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, 32'h0, 3'd0, 0, 1'b1);
    k = 1;
    sample(sel, ir, ov, od, oz, oe);
    while (ov !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
      sample(sel, ir, ov, od, oz, oe);
    end
    n_checks++;
    if (k != elat) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", nm, k, elat); end
    n_checks++;
    if (od !== ed) begin n_fail++; $display("FAIL %s data: got %h expected %h", nm, od, ed); end
    n_checks++;
    if (oz !== ez) begin n_fail++; $display("FAIL %s zero: got %b expected %b", nm, oz, ez); end
    n_checks++;
    if (oe !== ee) begin n_fail++; $display("FAIL %s err: got %b expected %b", nm, oe, ee); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic ir, ov, oz, oe;
    logic [31:0] od;
    #3;
    for (int s = 0; s < 2; s++) begin
      sample(s, ir, ov, od, oz, oe);
      n_checks++;
      if ({ir, ov, oz, oe} !== 4'b0000 || od !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got rdy=%b vld=%b data=%h z=%b e=%b expected all 0",
                 s, ir, ov, od, oz, oe);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed_a();
    run_op(0, 32'h8001, 3'd2, 1,  32'hC000, 1'b0, 1'b0, 4, "ror_8001_1");
    run_op(0, 32'h8001, 3'd0, 4,  32'h0018, 1'b0, 1'b0, 4, "rol_8001_4");
    run_op(0, 32'h8000, 3'd4, 15, 32'hFFFF, 1'b0, 1'b0, 4, "sra_8000_15");
    run_op(0, 32'h8000, 3'd3, 15, 32'h0001, 1'b0, 1'b0, 4, "srl_8000_15");
    run_op(0, 32'h00FF, 3'd1, 8,  32'hFF00, 1'b0, 1'b0, 4, "sll_00ff_8");
    for (int op = 0; op < 5; op++)
      run_op(0, 32'h1234, 3'(op), 0, 32'h1234, 1'b0, 1'b0, 4, $sformatf("cnt0_op%0d", op));
    run_op(0, 32'h8000, 3'd1, 1,  32'h0000, 1'b1, 1'b0, 4, "sll_to_zero");
    run_op(0, 32'hABCD, 3'd6, 3,  32'hABCD, 1'b0, 1'b1, 4, "illegal_110");
    run_op(0, 32'h0001, 3'd2, 1,  32'h8000, 1'b0, 1'b0, 4, "legal_after_illegal");
  endtask

  task automatic test_ror32();
    run_op(1, 32'h00000001, 3'd2, 31, 32'h00000002, 1'b0, 1'b0, 1, "ror32_cnt31");
    run_op(1, 32'h80000000, 3'd4, 31, 32'hFFFFFFFF, 1'b0, 1'b0, 1, "sra32_cnt31");
  endtask

  task automatic test_backpressure();
    logic [31:0] q[$];
    logic [31:0] d, od, prev_d;
    logic ir, ov, oz, oe, prev_hold, saw_low;
    int sent, got, last_cyc, c;
    logic [2:0] op;
    sent = 0; got = 0; last_cyc = 0; prev_hold = 0; prev_d = '0; saw_low = 0;
    for (int cyc = 1; cyc <= 40 && got < 6; cyc++) begin
      d  = 32'h1000 + 32'(sent) * 32'h0111;
      op = 3'(sent % 5);
      c  = sent + 1;
      drive(0, sent < 6, d, op, c, !(cyc >= 5 && cyc <= 7));
      #1;
      sample(0, ir, ov, od, oz, oe);
      if (a_in_valid && !ir) saw_low = 1'b1;
      if (prev_hold) begin
        n_checks++;
        if (od !== prev_d) begin
          n_fail++; $display("FAIL bp_stall_stable cyc%0d: got %h expected %h", cyc, od, prev_d);
        end
      end
      if (ov && a_out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL bp_order cyc%0d: got unexpected %h expected no output", cyc, od);
        end else begin
          if (od !== q[0]) begin
            n_fail++; $display("FAIL bp_order cyc%0d: got %h expected %h", cyc, od, q[0]);
          end
          void'(q.pop_front());
        end
        got++;
        last_cyc = cyc;
      end
      if (a_in_valid && ir) begin
        q.push_back(ref_model(16, d, op, c));
        sent++;
      end
      prev_hold = ov && !a_out_ready;
      prev_d    = od;
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 32'h0, 3'd0, 0, 1'b1);
    n_checks++;
    if (saw_low !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_low: got %b expected 1", saw_low); end
    n_checks++;
    if (got != 6) begin n_fail++; $display("FAIL bp_count: got %0d expected 6", got); end
    n_checks++;
    if (last_cyc != 13) begin n_fail++; $display("FAIL bp_resume: got last out cycle %0d expected 13", last_cyc); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 32'h0F00 + 32'(i), 3'd2, i + 1, 1'b0);
      @(posedge clk); #1;
    end
    drive(0, 1'b0, 32'h0, 3'd0, 0, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (a_out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: got out_valid %b expected 1", a_out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({a_out_valid, a_in_ready, a_out_zero, a_out_err} !== 4'b0000 || a_out_data !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got vld=%b rdy=%b data=%h z=%b e=%b expected all 0",
               a_out_valid, a_in_ready, a_out_data, a_out_zero, a_out_err);
    end
    #2 rst = 1'b0;
    run_op(0, 32'h00F0, 3'd3, 4, 32'h000F, 1'b0, 1'b0, 4, "post_reset_op");
  endtask

  task automatic test_random(input int sel, input int nops);
    logic [31:0] q_d[$];
    logic        q_z[$];
    logic        q_e[$];
    logic [31:0] d, od, prev_d, r;
    logic [2:0]  op;
    logic        v, rd, ir, ov, oz, oe, prev_hold, prev_z, prev_e;
    int          w, sent, got, cyc, c;
    w = (sel == 0) ? 16 : 32;
    sent = 0; got = 0; cyc = 0; prev_hold = 0; prev_d = '0; prev_z = 0; prev_e = 0;
    while (got < nops && cyc < 20000) begin
      d  = $urandom;
      if (w == 16) d = d & 32'h0000FFFF;
      op = 3'($urandom_range(0, 7));
      c  = $urandom_range(0, w - 1);
      v  = (sent < nops) && ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 9) < 7);
      drive(sel, v, d, op, c, rd);
      #1;
      sample(sel, ir, ov, od, oz, oe);
      if (prev_hold) begin
        n_checks++;
        if (od !== prev_d || oz !== prev_z || oe !== prev_e) begin
          n_fail++;
          $display("FAIL rnd%0d_hold: got %h/%b/%b expected %h/%b/%b", sel, od, oz, oe, prev_d, prev_z, prev_e);
        end
      end
      if (ov && rd) begin
        n_checks++;
        if (q_d.size() == 0) begin
          n_fail++; $display("FAIL rnd%0d_extra: got %h expected no output", sel, od);
        end else begin
          if (od !== q_d[0] || oz !== q_z[0] || oe !== q_e[0]) begin
            n_fail++;
            $display("FAIL rnd%0d_result #%0d: got %h z=%b e=%b expected %h z=%b e=%b",
                     sel, got, od, oz, oe, q_d[0], q_z[0], q_e[0]);
          end
          void'(q_d.pop_front()); void'(q_z.pop_front()); void'(q_e.pop_front());
        end
        got++;
      end
      if (v && ir) begin
        r = ref_model(w, d, op, c);
        q_d.push_back(r);
        q_z.push_back(r == 32'h0);
        q_e.push_back(op > 3'd4);
        sent++;
      end
      prev_hold = ov && !rd;
      prev_d = od; prev_z = oz; prev_e = oe;
      @(posedge clk); #1;
      cyc++;
    end
    drive(sel, 1'b0, 32'h0, 3'd0, 0, 1'b1);
    n_checks++;
    if (got != nops) begin n_fail++; $display("FAIL rnd%0d_count: got %0d expected %0d", sel, got, nops); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    drive(0, 1'b0, 32'h0, 3'd0, 0, 1'b1);
    drive(1, 1'b0, 32'h0, 3'd0, 0, 1'b1);
    test_reset();
    test_directed_a();
    test_ror32();
    test_backpressure();
    test_reset_midstream();
    test_random(0, 300);
    test_random(1, 1000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
